rom_wr_sequencer: RTL and testbench
===================================

# rom_wr_sequencer

Write-side feeder for the SDRAM test datapath. It walks the pattern ROM sequentially from a programmable base address and pushes each word into the SDRAM controller's write FIFO with a clean single-cycle write enable, honouring FIFO back-pressure. It replaces the ad-hoc flag/counter strobe generation in the top level with a proper state machine, and reports progress and completion for the display and debug logic.

## Interface
Parameters:
- `AW`, 16: ROM address width.
- `DSIZE`, 16: data word width; matches the SDRAM data bus.
- `ROM_LAT`, 1: cycles from `rom_addr` change to valid `rom_q`; legal range 1–3.

Ports:
- `sys_clk` input 1: single clock. The ROM and the write-FIFO write port both run on it.
- `sys_rst` input 1: synchronous, active-high reset.
- `start` input 1: one-cycle request to begin a burst. Sampled only in IDLE.
- `base_addr` input AW: first ROM address of the burst. Captured on an accepted `start`.
- `word_cnt` input AW: number of words to push. Captured on an accepted `start`. 0 means 2^AW words.
- `rom_addr` output AW: ROM address, registered.
- `rom_q` input DSIZE: ROM read data.
- `wr_full` input 1: write FIFO full.
- `wr_en` output 1: write strobe, high for exactly one cycle per word.
- `wr_data` output DSIZE: write data, valid while `wr_en` is high.
- `busy` output 1: high from an accepted `start` until the burst completes.
- `done` output 1: one-cycle pulse after the last word is pushed.
- `pushed` output AW: number of words pushed in the current or last burst.
- `checksum` output DSIZE: see Configuration.

## Operation
State machine: IDLE → FETCH → WAIT → PUSH → (FETCH | FIN) → IDLE.

- **IDLE**
  - `busy` = 0.
  - On `start`: latch `base_addr` into `rom_addr`, latch `word_cnt` into the remaining counter, clear `pushed` and `checksum`, then go to FETCH.
- **FETCH**: one cycle. `rom_addr` is stable; load the latency counter with ROM_LAT-1; go to WAIT.
- **WAIT**: count down. When the counter reaches 0, register `rom_q` into `wr_data` and go to PUSH.
- **PUSH**
  - If `wr_full` = 0: assert `wr_en` for this cycle, increment `pushed`, decrement the remaining counter, and increment `rom_addr` modulo 2^AW (wraps from all-ones to 0).
    - If remaining was 1: go to FIN.
    - Otherwise: go to FETCH.
  - If `wr_full` = 1: hold in PUSH with `wr_en` = 0 and `wr_data` held. No word is lost or duplicated.
- **FIN**: pulse `done`, then go to IDLE.

General rules:
- `start` outside IDLE is ignored; no queuing.
- `wr_en` is driven combinationally from state and `wr_full`. All other outputs are registered.
- `pushed` saturates at neither end; it wraps modulo 2^AW. With `word_cnt` = 0 it reads 0 after a full 2^AW burst.

## Timing
- Reset values:
  - `rom_addr` = 0, `wr_en` = 0, `wr_data` = 0
  - `busy` = 0, `done` = 0, `pushed` = 0, `checksum` = 0
  - state = IDLE
- `start` accepted at edge T: `busy` = 1 from T+1, `rom_addr` = base from T+1.
- First `wr_en` (FIFO not full) occurs in cycle T+2+ROM_LAT.
- Throughput without back-pressure: one word every ROM_LAT+2 cycles.
- `done` is high in the cycle after the last `wr_en`. `busy` falls together with `done` going low, i.e. 2 cycles after the last `wr_en`.
- `sys_rst` mid-burst: return to IDLE on the next edge with all reset values. `wr_en` is 0 in the cycle `sys_rst` is high.
- `start` and `sys_rst` high together: reset wins.

## Configuration
- `ROM_WR_SEQ_CHECKSUM_EN`
  - **Defined:** `checksum` accumulates the modulo-2^DSIZE sum of every word actually pushed (on `wr_en`). It is cleared on an accepted `start` and holds after `done`.
  - **Undefined:** `checksum` is tied to 0 and no accumulator logic is built.

## Structure
- Shared package `sdram_test_pkg`: state encoding typedef (IDLE, FETCH, WAIT, PUSH, FIN) and the ROM_LAT range limits.
- One natural sub-module, `rom_wr_checksum`: the accumulator, instantiated only under the macro.
- The `AW` and `DSIZE` defaults match the project-wide ASIZE/DSIZE header values.

## Test plan
- **Basic burst:** ROM_LAT=1, ROM content = address, `base_addr`=0, `word_cnt`=4, `wr_full`=0.
  - Expect `wr_en` pulses in cycles T+3, T+6, T+9, T+12 with data 0,1,2,3.
  - Expect `done` at T+13 and `pushed`=4.
- **Back-pressure:** hold `wr_full`=1 for 5 cycles during the second PUSH.
  - Expect `wr_data`=1 held, no `wr_en` while full, then a single `wr_en` with 1 on release.
  - Expect total pushes = 4.
- **Address wrap:** AW=4, `base_addr`=14, `word_cnt`=4.
  - Expect `rom_addr` sequence 14,15,0,1 and data 14,15,0,1.
- **Reset mid-burst:** assert `sys_rst` during WAIT of word 2.
  - Expect IDLE, `busy`=0, `pushed`=0, and no `wr_en` afterwards.
  - A new `start` then behaves as the basic burst.
- **Ignored start / latency:** pulse `start` while `busy`; expect no effect on count or address. Repeat the basic burst with ROM_LAT=3; expect one `wr_en` every 5 cycles.
- **Checksum:** with `ROM_WR_SEQ_CHECKSUM_EN`, pushing words 0x8000 and 0x8001 gives `checksum`=0x0001. Without the macro, `checksum`=0 throughout.

Source files
------------

// File: rtl/sdram_test_pkg.sv
// Shared types and limits for the SDRAM test datapath.
package sdram_test_pkg;

  localparam int unsigned SDRAM_ASIZE = 16;
  localparam int unsigned SDRAM_DSIZE = 16;

  localparam int unsigned ROM_LAT_MIN = 1;
  localparam int unsigned ROM_LAT_MAX = 3;
  localparam int unsigned LAT_CNT_W   = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_PUSH,
    ST_FIN
  } seq_state_e;

endpackage

// File: rtl/rom_wr_checksum.sv
// Modulo-2^DSIZE accumulator of pushed words; cleared per burst.
module rom_wr_checksum
  import sdram_test_pkg::*;
#(
  parameter int unsigned DSIZE = SDRAM_DSIZE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [DSIZE-1:0] data,
  output logic [DSIZE-1:0] sum
);

  logic [DSIZE-1:0] sum_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sum_q <= '0;
    end else if (en) begin
      sum_q <= sum_q + data;
    end
  end

  assign sum = sum_q;

endmodule

// File: rtl/rom_wr_sequencer.sv
// Walks the pattern ROM from a base address and pushes each word into the SDRAM write FIFO.
// Optional running checksum of pushed words under ROM_WR_SEQ_CHECKSUM_EN.
module rom_wr_sequencer
  import sdram_test_pkg::*;
#(
  parameter int unsigned AW      = SDRAM_ASIZE,
  parameter int unsigned DSIZE   = SDRAM_DSIZE,
  parameter int unsigned ROM_LAT = 1
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             start,
  input  logic [AW-1:0]    base_addr,
  input  logic [AW-1:0]    word_cnt,
  output logic [AW-1:0]    rom_addr,
  input  logic [DSIZE-1:0] rom_q,
  input  logic             wr_full,
  output logic             wr_en,
  output logic [DSIZE-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    pushed,
  output logic [DSIZE-1:0] checksum
);

  if (ROM_LAT < ROM_LAT_MIN || ROM_LAT > ROM_LAT_MAX) begin : g_lat_range
    $error("rom_wr_sequencer: ROM_LAT outside supported range");
  end

  seq_state_e             state_q;
  logic [AW-1:0]          addr_q;
  logic [AW-1:0]          remain_q;
  logic [AW-1:0]          pushed_q;
  logic [LAT_CNT_W-1:0]   lat_q;
  logic [DSIZE-1:0]       wr_data_q;
  logic                   busy_q;
  logic                   done_q;

  // Strobe is the only combinational output; suppressed while reset is asserted.
  assign wr_en = (state_q == ST_PUSH) && !wr_full && !sys_rst;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      remain_q  <= '0;
      pushed_q  <= '0;
      lat_q     <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            addr_q   <= base_addr;
            remain_q <= word_cnt;
            pushed_q <= '0;
            busy_q   <= 1'b1;
            state_q  <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          lat_q   <= LAT_CNT_W'(ROM_LAT - 1);
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (lat_q == '0) begin
            wr_data_q <= rom_q;
            state_q   <= ST_PUSH;
          end else begin
            lat_q <= lat_q - LAT_CNT_W'(1);
          end
        end
        ST_PUSH: begin
          // A zero word_cnt underflows here and runs the full 2^AW words.
          if (!wr_full) begin
            pushed_q <= pushed_q + AW'(1);
            remain_q <= remain_q - AW'(1);
            addr_q   <= addr_q + AW'(1);
            if (remain_q == AW'(1)) begin
              done_q  <= 1'b1;
              state_q <= ST_FIN;
            end else begin
              state_q <= ST_FETCH;
            end
          end
        end
        ST_FIN: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign rom_addr = addr_q;
  assign wr_data  = wr_data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pushed   = pushed_q;

`ifdef ROM_WR_SEQ_CHECKSUM_EN
  logic start_acc;
  assign start_acc = (state_q == ST_IDLE) && start;

  rom_wr_checksum #(
    .DSIZE (DSIZE)
  ) u_checksum (
    .clk  (sys_clk),
    .rst  (sys_rst),
    .clr  (start_acc),
    .en   (wr_en),
    .data (wr_data_q),
    .sum  (checksum)
  );
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_rom_wr_sequencer.sv
// Bench for rom_wr_sequencer: two instances (AW=4/ROM_LAT=1 and AW=16/ROM_LAT=3) checked every cycle
// against a transaction-level model of the burst.
module tb_rom_wr_sequencer;

`ifdef ROM_WR_SEQ_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  logic [1:0]       start_v;
  logic [1:0]       full_v;
  logic [1:0][15:0] base_v;
  logic [1:0][15:0] cnt_v;

  logic [3:0]  rom_addr_a, pushed_a;
  logic [15:0] rom_q_a, wr_data_a, checksum_a;
  logic        wr_en_a, busy_a, done_a;
  logic [15:0] rom_addr_b, pushed_b, rom_q_b, wr_data_b, checksum_b;
  logic        wr_en_b, busy_b, done_b;

  logic [1:0][15:0] o_addr, o_data, o_pushed, o_sum;
  logic [1:0]       o_wen, o_busy, o_done;

  logic [15:0] mem_a [16];
  logic [15:0] pa, pb1, pb2, pb3;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state, one slot per instance
  int edge_n = 0;
  int phase [2];
  int elig [2];
  int rem [2];
  int t_start [2];
  int exp_addr [2];
  int exp_data [2];
  int exp_pushed [2];
  int exp_sum [2];
  int exp_busy [2];
  int exp_done [2];

  int sel_d = 0;
  int stamps [$];
  int sdata [$];

  rom_wr_sequencer #(.AW(4), .DSIZE(16), .ROM_LAT(1)) u_dut_a (
    .sys_clk   (clk),
    .sys_rst   (rst),
    .start     (start_v[0]),
    .base_addr (base_v[0][3:0]),
    .word_cnt  (cnt_v[0][3:0]),
    .rom_addr  (rom_addr_a),
    .rom_q     (rom_q_a),
    .wr_full   (full_v[0]),
    .wr_en     (wr_en_a),
    .wr_data   (wr_data_a),
    .busy      (busy_a),
    .done      (done_a),
    .pushed    (pushed_a),
    .checksum  (checksum_a)
  );

  rom_wr_sequencer #(.AW(16), .DSIZE(16), .ROM_LAT(3)) u_dut_b (
    .sys_clk   (clk),
    .sys_rst   (rst),
    .start     (start_v[1]),
    .base_addr (base_v[1]),
    .word_cnt  (cnt_v[1]),
    .rom_addr  (rom_addr_b),
    .rom_q     (rom_q_b),
    .wr_full   (full_v[1]),
    .wr_en     (wr_en_b),
    .wr_data   (wr_data_b),
    .busy      (busy_b),
    .done      (done_b),
    .pushed    (pushed_b),
    .checksum  (checksum_b)
  );

  assign o_addr[0]   = 16'(rom_addr_a);
  assign o_addr[1]   = rom_addr_b;
  assign o_data[0]   = wr_data_a;
  assign o_data[1]   = wr_data_b;
  assign o_pushed[0] = 16'(pushed_a);
  assign o_pushed[1] = pushed_b;
  assign o_sum[0]    = checksum_a;
  assign o_sum[1]    = checksum_b;
  assign o_wen       = {wr_en_b, wr_en_a};
  assign o_busy      = {busy_b, busy_a};
  assign o_done      = {done_b, done_a};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM models: instance a is a table with 1-cycle latency, instance b returns its address after 3 cycles
  always @(posedge clk) begin
    pa  <= mem_a[rom_addr_a];
    pb1 <= rom_addr_b;
    pb2 <= pb1;
    pb3 <= pb2;
  end
  assign rom_q_a = pa;
  assign rom_q_b = pb3;

  function automatic int mask_of(input int d);
    return (d == 0) ? 15 : 65535;
  endfunction

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic int rom_word(input int d, input int a);
    if (d == 0) return int'(mem_a[a & 15]);
    return a & 65535;
  endfunction

  function automatic int exp_wen(input int d);
    return (phase[d] == 1 && edge_n >= elig[d] && !full_v[d] && !rst) ? 1 : 0;
  endfunction

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  // Burst model: phase 0 idle, 1 running, 2 done cycle. A word becomes pushable at edge elig and
  // goes out in the first such cycle with the FIFO not full; the next word is ROM_LAT+2 cycles later.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        phase[d] = 0; exp_addr[d] = 0; exp_data[d] = 0; exp_pushed[d] = 0;
        exp_sum[d] = 0; exp_busy[d] = 0; exp_done[d] = 0;
      end else if (phase[d] == 2) begin
        phase[d] = 0; exp_busy[d] = 0; exp_done[d] = 0;
      end else if (phase[d] == 1) begin
        if (edge_n >= elig[d] && !full_v[d]) begin
          exp_sum[d]    = (exp_sum[d] + exp_data[d]) & 65535;
          exp_pushed[d] = (exp_pushed[d] + 1) & mask_of(d);
          exp_addr[d]   = (exp_addr[d] + 1) & mask_of(d);
          rem[d]        = rem[d] - 1;
          if (rem[d] == 0) begin
            phase[d] = 2; exp_done[d] = 1;
          end else begin
            elig[d] = edge_n + lat_of(d) + 2;
          end
        end
      end else if (start_v[d]) begin
        phase[d]      = 1;
        exp_busy[d]   = 1;
        exp_addr[d]   = int'(base_v[d]) & mask_of(d);
        rem[d]        = ((int'(cnt_v[d]) & mask_of(d)) == 0) ? mask_of(d) + 1 : int'(cnt_v[d]) & mask_of(d);
        exp_pushed[d] = 0;
        exp_sum[d]    = 0;
        elig[d]       = edge_n + 2 + lat_of(d);
        t_start[d]    = edge_n + 1;
      end
      if (!rst && phase[d] == 1 && edge_n + 1 == elig[d]) exp_data[d] = rom_word(d, exp_addr[d]);
    end
    edge_n++;
  end

  always @(negedge clk) begin
    if (edge_n > 0) begin
      for (int d = 0; d < 2; d++) begin
        string s;
        s = (d == 0) ? "a_" : "b_";
        check_eq({s, "wr_en"},    int'(o_wen[d]),   exp_wen(d));
        check_eq({s, "wr_data"},  int'(o_data[d]),  exp_data[d]);
        check_eq({s, "rom_addr"}, int'(o_addr[d]),  exp_addr[d]);
        check_eq({s, "busy"},     int'(o_busy[d]),  exp_busy[d]);
        check_eq({s, "done"},     int'(o_done[d]),  exp_done[d]);
        check_eq({s, "pushed"},   int'(o_pushed[d]), exp_pushed[d]);
        check_eq({s, "checksum"}, int'(o_sum[d]),   CSUM_EN ? exp_sum[d] : 0);
      end
      if (o_wen[sel_d]) begin
        stamps.push_back(edge_n);
        sdata.push_back(int'(o_data[sel_d]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_burst(input int d, input int base, input int cnt);
    sel_d = d;
    stamps.delete();
    sdata.delete();
    base_v[d]  = 16'(base);
    cnt_v[d]   = 16'(cnt);
    start_v[d] = 1'b1;
    tick();
    start_v[d] = 1'b0;
  endtask

  task automatic wait_idle(input int d, input int budget, input bit rnd);
    for (int i = 0; i < budget; i++) begin
      tick();
      if (!o_busy[d]) break;
      if (rnd) begin
        full_v[d]  = ($urandom % 3 == 0);
        start_v[d] = (phase[d] == 1 && $urandom % 8 == 0);
        base_v[d]  = 16'($urandom);
        cnt_v[d]   = 16'($urandom);
      end
    end
    full_v[d]  = 1'b0;
    start_v[d] = 1'b0;
    check_eq("idle_timeout", int'(o_busy[d]), 0);
  endtask

  // No back-pressure: first push ROM_LAT+1 edges after acceptance, then every ROM_LAT+2.
  task automatic check_stamps(input int d, input int n);
    check_eq("n_pushes", stamps.size(), n);
    if (stamps.size() > 0) check_eq("first_lat", stamps[0] - t_start[d], lat_of(d) + 1);
    for (int i = 1; i < stamps.size(); i++) check_eq("push_gap", stamps[i] - stamps[i-1], lat_of(d) + 2);
  endtask

  task automatic run_basic(input int d);
    start_burst(d, 0, 4);
    wait_idle(d, 200, 1'b0);
    check_stamps(d, 4);
    for (int i = 0; i < sdata.size(); i++) check_eq("basic_data", sdata[i], i);
    check_eq("basic_pushed", int'(o_pushed[d]), 4);
  endtask

  initial begin
    int e_bp;
    int d;
    rst     = 1'b1;
    start_v = '0;
    full_v  = '0;
    base_v  = '0;
    cnt_v   = '0;
    for (int i = 0; i < 16; i++) mem_a[i] = 16'(i);
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_eq("rst_busy",   int'(o_busy[0]),   0);
    check_eq("rst_addr",   int'(o_addr[1]),   0);
    check_eq("rst_pushed", int'(o_pushed[0]), 0);
    check_eq("rst_data",   int'(o_data[1]),   0);

    // basic burst, ROM content = address
    run_basic(0);

    // back-pressure held for 5 cycles on the second word
    start_burst(0, 0, 4);
    for (int i = 0; i < 100; i++) begin
      if (exp_pushed[0] == 1 && edge_n >= elig[0]) break;
      tick();
    end
    e_bp = edge_n;
    full_v[0] = 1'b1;
    repeat (5) tick();
    full_v[0] = 1'b0;
    wait_idle(0, 200, 1'b0);
    check_eq("bp_pushes", stamps.size(), 4);
    if (stamps.size() == 4) begin
      check_eq("bp_release", stamps[1], e_bp + 5);
      check_eq("bp_data", sdata[1], 1);
    end
    check_eq("bp_pushed", int'(o_pushed[0]), 4);

    // address wrap in a 4-bit space
    start_burst(0, 14, 4);
    wait_idle(0, 200, 1'b0);
    check_eq("wrap_n", sdata.size(), 4);
    for (int i = 0; i < sdata.size(); i++) check_eq("wrap_data", sdata[i], (14 + i) & 15);
    check_eq("wrap_addr", int'(o_addr[0]), 2);

    // start while busy is ignored
    start_burst(0, 0, 3);
    tick();
    base_v[0] = 16'd9; cnt_v[0] = 16'd7; start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    wait_idle(0, 200, 1'b0);
    check_eq("ign_pushed", int'(o_pushed[0]), 3);
    check_eq("ign_addr", int'(o_addr[0]), 3);

    // reset during WAIT of the second word, then a fresh basic burst
    start_burst(0, 0, 4);
    for (int i = 0; i < 100; i++) begin
      if (exp_pushed[0] == 1 && edge_n + 1 == elig[0]) break;
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("mid_rst_busy", int'(o_busy[0]), 0);
    check_eq("mid_rst_pushed", int'(o_pushed[0]), 0);
    stamps.delete();
    repeat (10) tick();
    check_eq("mid_rst_no_wen", stamps.size(), 0);
    run_basic(0);

    // start and reset together: reset wins
    start_v[0] = 1'b1; rst = 1'b1; base_v[0] = 16'd3; cnt_v[0] = 16'd2;
    tick();
    start_v[0] = 1'b0; rst = 1'b0;
    tick();
    check_eq("rst_start_busy", int'(o_busy[0]), 0);
    check_eq("rst_start_addr", int'(o_addr[0]), 0);

    // word_cnt = 0 runs the full address space
    start_burst(0, 5, 0);
    wait_idle(0, 200, 1'b0);
    check_eq("full_n", stamps.size(), 16);
    check_eq("full_pushed", int'(o_pushed[0]), 0);
    check_eq("full_addr", int'(o_addr[0]), 5);

    // ROM_LAT = 3 instance
    run_basic(1);

    // checksum wrap: 0x8000 + 0x8001
    start_burst(1, 16'h8000, 2);
    wait_idle(1, 200, 1'b0);
    check_eq("csum", int'(o_sum[1]), CSUM_EN ? 1 : 0);
    repeat (3) tick();
    check_eq("csum_hold", int'(o_sum[1]), CSUM_EN ? 1 : 0);

    // randomized bursts with random back-pressure and stray starts
    for (int i = 0; i < 16; i++) mem_a[i] = 16'($urandom);
    for (int it = 0; it < 30; it++) begin
      d = int'($urandom % 2);
      start_burst(d, int'($urandom), (d == 0) ? int'($urandom % 16) : 1 + int'($urandom % 6));
      wait_idle(d, 1000, 1'b1);
      repeat (int'($urandom % 3)) tick();
    end

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
